t05_pipeline_sequencer: RTL
===========================

T05_PIPELINE_SEQUENCER -- requirements
Module: t05_pipeline_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 20'd1_000_000, the maximum number of cycles spent in any one stage state.
REQ-002 SHALL have parameter CNT_W, default 20, the width of the watchdog counter.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  begin one compression run, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  cancel the run and return to IDLE.
REQ-007 SHALL have port ack  input  1  acknowledge DONE or ERROR and return to IDLE.
REQ-008 SHALL have port stage_done  input  6  per-stage completion; bit0 HISTO, bit1 FLV, bit2 HTREE, bit3 CBS, bit4 TRN, bit5 SPI.
REQ-009 SHALL have port stage_err  input  6  per-stage error, same bit order as stage_done.
REQ-010 SHALL have port stage_start  output  6  one-cycle start pulse to a stage, same bit order.
REQ-011 SHALL have port cont_state  output  4  current state code, consumed by the display controller.
REQ-012 SHALL have port busy  output  1  high in any stage state (HISTO..SPI).
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port err_code  output  4  state code of the stage that failed; valid in ERROR.
REQ-015 SHALL have port timeout_flag  output  1  high in ERROR when the error cause was the watchdog.

Function
REQ-016 SHALL use state encoding IDLE=0, HISTO=1, FLV=2, HTREE=3, CBS=4, TRN=5, SPI=6, ERROR=7, DONE=8; codes 9-15 SHALL go to IDLE on the next edge.
REQ-017 SHALL drive cont_state directly from the state register, with no combinational path from inputs.
REQ-018 In IDLE, start=1 and abort=0 SHALL move the block to HISTO on the next edge; start outside IDLE SHALL be ignored.
REQ-019 On every entry into stage state S (HISTO..SPI), stage_start SHALL be one-hot on bit S-1 for exactly the first cycle in S and zero otherwise.
REQ-020 In stage state S, stage_done[S-1]=1 SHALL advance the state (HISTO->FLV->HTREE->CBS->TRN->SPI->DONE) on the next edge.
REQ-021 stage_done and stage_err bits of non-active stages SHALL be ignored.
REQ-022 stage_done SHALL be honoured in any cycle in S, including the stage_start cycle.
REQ-023 In S, stage_err[S-1]=1 SHALL move to ERROR with err_code<=S and timeout_flag<=0.
REQ-024 If stage_err[S-1] and stage_done[S-1] are high in the same cycle, the error SHALL win.
REQ-025 The watchdog counter SHALL clear to 0 on every state entry and increment by 1 each cycle in a stage state.
REQ-026 When the count equals TIMEOUT-1 and no done/err is present, the block SHALL go to ERROR with err_code<=S and timeout_flag<=1.
REQ-027 A done or err arriving in the terminal watchdog cycle SHALL take priority over the timeout.
REQ-028 abort=1 in any state except IDLE SHALL move to IDLE on the next edge, with priority over done, err, timeout and ack.
REQ-029 An abort SHALL clear err_code and timeout_flag and SHALL NOT emit stage_start.
REQ-030 In IDLE, start and abort high together SHALL leave the block in IDLE.
REQ-031 DONE and ERROR SHALL hold until ack=1, then go to IDLE on the next edge, clearing err_code and timeout_flag.
REQ-032 ack in any other state SHALL be ignored.
REQ-033 busy SHALL equal 1 for states 1..6; done SHALL equal 1 for state 8 only.

Reset
REQ-034 While nrst=0 at a rising edge, the block SHALL reset state=IDLE, counter=0, stage_start=0, err_code=0, timeout_flag=0; this gives cont_state=0, busy=0 and done=0.
REQ-035 Reset mid-run SHALL abandon the run without emitting stage_start; reset SHALL override all other inputs.

Verification
REQ-036 Happy path: start pulse, then each stage_done 3 cycles after its stage_start -> cont_state 1..6 then 8, six single-cycle stage_start pulses 0x01..0x20 in order, done=1 until ack, then cont_state=0.
REQ-037 Stage error: stage_err[2] during HTREE -> cont_state=7, err_code=3, timeout_flag=0; ack -> cont_state=0, err_code=0.
REQ-038 Watchdog: TIMEOUT=8, no done during CBS -> ERROR exactly 8 cycles after CBS entry, err_code=4, timeout_flag=1; with stage_done[3] on count 7 -> TRN instead.
REQ-039 Collisions: stage_done[0] and stage_err[0] together in HISTO -> ERROR, err_code=1; abort and stage_done together in FLV -> IDLE; wrong-bit stage_done[4] in FLV -> no change.
REQ-040 Reset and illegal inputs: nrst=0 for one cycle while in TRN -> cont_state=0 and stage_start=0 next cycle; start while busy -> no effect; ack in IDLE -> no effect.

Source files
------------

// File: rtl/t05_pipeline_sequencer.sv
// ---------------------------------------------------------------------------
// t05_pipeline_sequencer
//
// Purpose:
//   Top-level sequencer for one compression run. It walks six processing
//   stages in order (HISTO, FLV, HTREE, CBS, TRN, SPI) and then reports DONE.
//   Each stage gets a one-cycle start pulse when it is entered. The sequencer
//   then waits for that stage's completion or error bit. A per-state watchdog
//   sends the block to ERROR if a stage never answers. ERROR and DONE are
//   held until the host acknowledges them. abort returns the block to IDLE
//   from any state.
//
// Parameters:
//   TIMEOUT      maximum number of cycles spent in any one stage state
//   CNT_W        width of the watchdog counter
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   nrst         synchronous active-low reset
//   start        begin one run (sampled in IDLE only)
//   abort        cancel the run and return to IDLE
//   ack          acknowledge DONE or ERROR and return to IDLE
//   stage_done   per-stage completion (bit0 HISTO .. bit5 SPI)
//   stage_err    per-stage error, same bit order as stage_done
//   stage_start  one-cycle start pulse to a stage, same bit order
//   cont_state   current state code for the display controller
//   busy         high in any stage state (HISTO..SPI)
//   done         high in DONE
//   err_code     state code of the failing stage, valid in ERROR
//   timeout_flag high in ERROR when the watchdog caused the error
// ---------------------------------------------------------------------------
module t05_pipeline_sequencer #(
    parameter int unsigned TIMEOUT = 20'd1_000_000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic       abort,
    input  logic       ack,
    input  logic [5:0] stage_done,
    input  logic [5:0] stage_err,
    output logic [5:0] stage_start,
    output logic [3:0] cont_state,
    output logic       busy,
    output logic       done,
    output logic [3:0] err_code,
    output logic       timeout_flag
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HISTO = 4'd1,
        ST_FLV   = 4'd2,
        ST_HTREE = 4'd3,
        ST_CBS   = 4'd4,
        ST_TRN   = 4'd5,
        ST_SPI   = 4'd6,
        ST_ERROR = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

    // Count value of the last cycle a stage may occupy before the watchdog fires.
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       stage_start_q, stage_start_d;
    logic [3:0]       err_code_q, err_code_d;
    logic             timeout_flag_q, timeout_flag_d;

    logic [5:0]       active_mask;
    logic             hit_done;
    logic             hit_err;

    // One-hot bit of the stage owned by a state; zero for non-stage states.
    function automatic logic [5:0] stage_mask(input state_e s);
        case (s)
            ST_HISTO: stage_mask = 6'b000001;
            ST_FLV:   stage_mask = 6'b000010;
            ST_HTREE: stage_mask = 6'b000100;
            ST_CBS:   stage_mask = 6'b001000;
            ST_TRN:   stage_mask = 6'b010000;
            ST_SPI:   stage_mask = 6'b100000;
            default:  stage_mask = 6'b000000;
        endcase
    endfunction

    // Successor of a stage state on successful completion.
    function automatic state_e next_stage(input state_e s);
        case (s)
            ST_HISTO: next_stage = ST_FLV;
            ST_FLV:   next_stage = ST_HTREE;
            ST_HTREE: next_stage = ST_CBS;
            ST_CBS:   next_stage = ST_TRN;
            ST_TRN:   next_stage = ST_SPI;
            ST_SPI:   next_stage = ST_DONE;
            default:  next_stage = ST_IDLE;
        endcase
    endfunction

    // Masking with the active stage bit makes the sequencer ignore done and
    // err bits from stages that are not running.
    always_comb begin
        active_mask = stage_mask(state_q);
        hit_done    = |(stage_done & active_mask);
        hit_err     = |(stage_err & active_mask);
    end

    // Next-state logic. Within a stage the priority is abort, then err, then
    // done, then watchdog expiry. A done or err in the terminal watchdog cycle
    // therefore beats the timeout. The counter defaults to zero, so every
    // state change clears it. It only counts up while the block stays in a
    // stage. stage_start is registered, so the pulse lines up with the first
    // cycle in the new stage.
    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        stage_start_d  = 6'b000000;
        err_code_d     = err_code_q;
        timeout_flag_d = timeout_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d       = ST_HISTO;
                    stage_start_d = stage_mask(ST_HISTO);
                end
            end

            ST_HISTO, ST_FLV, ST_HTREE, ST_CBS, ST_TRN, ST_SPI: begin
                if (abort) begin
                    state_d        = ST_IDLE;
                    err_code_d     = 4'd0;
                    timeout_flag_d = 1'b0;
                end else if (hit_err) begin
                    state_d        = ST_ERROR;
                    err_code_d     = state_q;
                    timeout_flag_d = 1'b0;
                end else if (hit_done) begin
                    state_d       = next_stage(state_q);
                    stage_start_d = stage_mask(next_stage(state_q));
                end else if (cnt_q == WDOG_LAST) begin
                    state_d        = ST_ERROR;
                    err_code_d     = state_q;
                    timeout_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_ERROR, ST_DONE: begin
                if (abort || ack) begin
                    state_d        = ST_IDLE;
                    err_code_d     = 4'd0;
                    timeout_flag_d = 1'b0;
                end
            end

            // Unused codes 9-15 fall back to IDLE with clean status.
            default: begin
                state_d        = ST_IDLE;
                err_code_d     = 4'd0;
                timeout_flag_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs. Reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            stage_start_q  <= 6'b000000;
            err_code_q     <= 4'd0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stage_start_q  <= stage_start_d;
            err_code_q     <= err_code_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    // Status outputs are pure decodes of the state register.
    assign cont_state   = state_q;
    assign busy         = (state_q >= ST_HISTO) && (state_q <= ST_SPI);
    assign done         = (state_q == ST_DONE);
    assign stage_start  = stage_start_q;
    assign err_code     = err_code_q;
    assign timeout_flag = timeout_flag_q;

endmodule
